// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock: N-port round-robin arbiter with a registered one-hot grant,
// per-port enable masking and lockable multi-cycle tenure.
// Optional feature macro: ARB_MAX_HOLD_EN bounds a locked tenure to MAX_HOLD
// cycles (when other ports are waiting) and raises a one-cycle preempt pulse.
module rr_arbiter_lock #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8,
    localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  en,
    input  logic [N-1:0]  lock,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id,
    output logic          preempt
);

    // Reject configurations outside the supported range at elaboration time.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("rr_arbiter_lock: N must be in 2..16");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_arbiter_lock: MAX_HOLD must be in 1..255");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic          grant_valid_q, grant_valid_d;

    logic [N-1:0]  eligible;
    logic [N-1:0]  cand;
    logic [IW-1:0] ptr_idx;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic          cont;
    logic          force_end;
    logic          new_grant;

`ifdef ARB_MAX_HOLD_EN
    logic [7:0]    hold_q, hold_d;
    logic          preempt_q, preempt_d;
`endif

    assign eligible = req & en;

    // Current holder keeps the grant while it still requests, is enabled and locks.
    assign cont = (state_q == ST_GRANT) && (|(grant_q & eligible & lock));

`ifdef ARB_MAX_HOLD_EN
    // A tenure that has reached MAX_HOLD is ended only if someone else is waiting.
    assign force_end = cont && (hold_q >= 8'(MAX_HOLD)) && (|(eligible & ~grant_q));
`else
    assign force_end = 1'b0;
`endif

    // On a forced end the current holder is excluded from the scan.
    assign cand = force_end ? (eligible & ~grant_q) : eligible;

    // Decode the one-hot priority pointer into an index.
    always_comb begin
        ptr_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ptr_q[i]) ptr_idx = IW'(i);
        end
    end

    // Cyclic scan from ptr: first the upper segment [ptr..N-1], then the wrap [0..ptr-1].
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!win_found && cand[i] && (i >= 32'(ptr_idx))) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!win_found && cand[i] && (i < 32'(ptr_idx))) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        new_grant     = 1'b0;
        if (cont && !force_end) begin
            state_d = ST_GRANT;
        end else if (win_found) begin
            state_d          = ST_GRANT;
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            grant_id_d       = win_idx;
            // Pointer restarts one past the new winner (rotate-left of the one-hot grant).
            ptr_d            = {grant_d[N-2:0], grant_d[N-1]};
            new_grant        = 1'b1;
        end else begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            grant_id_d = '0;
        end
        grant_valid_d = |grant_d;
    end

`ifdef ARB_MAX_HOLD_EN
    // Hold counter: 1 on the first cycle of a tenure, saturating at MAX_HOLD.
    always_comb begin
        hold_d    = hold_q;
        preempt_d = force_end;
        if (new_grant) begin
            hold_d = 8'd1;
        end else if (state_d == ST_IDLE) begin
            hold_d = '0;
        end else if (hold_q < 8'(MAX_HOLD)) begin
            hold_d = hold_q + 8'd1;
        end
    end
`endif

    // State, pointer and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= N'(1);
`ifdef ARB_MAX_HOLD_EN
            hold_q        <= '0;
            preempt_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            ptr_q         <= ptr_d;
`ifdef ARB_MAX_HOLD_EN
            hold_q        <= hold_d;
            preempt_q     <= preempt_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
`ifdef ARB_MAX_HOLD_EN
    assign preempt     = preempt_q;
`else
    assign preempt     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Directed self-checking bench for rr_arbiter_lock with N=4, MAX_HOLD=4.
// Works with or without ARB_MAX_HOLD_EN defined.
module tb_rr_arbiter_lock;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] req;
    logic [N-1:0] en;
    logic [N-1:0] lock;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         preempt;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    rr_arbiter_lock #(
        .N        (4),
        .MAX_HOLD (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .en          (en),
        .lock        (lock),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .preempt     (preempt)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'hF;
        en      = 4'hF;
        lock    = 4'h0;
        repeat (3) step();
        compared++;
        if (grant !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000);
        end
        compared++;
        if (grant_valid !== 1'b0 || grant_id !== 2'd0 || preempt !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got valid=%b id=%0d preempt=%b expected 0/0/0",
                     grant_valid, grant_id, preempt);
        end
        reset_n = 1'b1;
        step();
        compared++;
        if (grant !== 4'b0001 || grant_id !== 2'd0 || grant_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_first_grant: got %b id=%0d valid=%b expected 0001 id=0 valid=1",
                     grant, grant_id, grant_valid);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] tg [0:4];
        logic [1:0] ti [0:4];
        tg = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        ti = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            step();
            compared++;
            if (grant !== tg[i] || grant_id !== ti[i] || grant_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL rotation step %0d: got %b id=%0d valid=%b expected %b id=%0d valid=1",
                         i, grant, grant_id, grant_valid, tg[i], ti[i]);
            end
        end
    endtask

    task automatic test_mask_wrap();
        logic [3:0] tg [0:3];
        logic [1:0] ti [0:3];
        tg = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        ti = '{2'd3, 2'd1, 2'd3, 2'd1};
        en = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            compared++;
            if (grant !== tg[i] || grant_id !== ti[i]) begin
                mismatched++;
                $display("FAIL mask_wrap step %0d: got %b id=%0d expected %b id=%0d",
                         i, grant, grant_id, tg[i], ti[i]);
            end
        end
        en = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            compared++;
            if (grant !== 4'b0000 || grant_id !== 2'd0 || grant_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL mask_all_off step %0d: got %b id=%0d valid=%b expected 0000 id=0 valid=0",
                         i, grant, grant_id, grant_valid);
            end
        end
    endtask

    task automatic test_lock();
        en   = 4'hF;
        req  = 4'hF;
        lock = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step();
            compared++;
            if (grant !== 4'b0100 || grant_id !== 2'd2 || preempt !== 1'b0) begin
                mismatched++;
                $display("FAIL lock_hold cycle %0d: got %b id=%0d preempt=%b expected 0100 id=2 preempt=0",
                         i, grant, grant_id, preempt);
            end
        end
        lock = 4'b0000;
        step();
        compared++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            mismatched++;
            $display("FAIL lock_release: got %b id=%0d expected 1000 id=3", grant, grant_id);
        end
        step();
        compared++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            mismatched++;
            $display("FAIL lock_after_wrap: got %b id=%0d expected 0001 id=0", grant, grant_id);
        end
    endtask

    task automatic test_preempt();
        req  = 4'b0011;
        lock = 4'b0010;
        step();
        compared++;
        if (grant !== 4'b0010 || grant_id !== 2'd1) begin
            mismatched++;
            $display("FAIL preempt_entry: got %b id=%0d expected 0010 id=1", grant, grant_id);
        end
`ifdef ARB_MAX_HOLD_EN
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (grant !== 4'b0010 || preempt !== 1'b0) begin
                mismatched++;
                $display("FAIL preempt_hold cycle %0d: got %b preempt=%b expected 0010 preempt=0",
                         i, grant, preempt);
            end
        end
        step();
        compared++;
        if (grant !== 4'b0001 || grant_id !== 2'd0 || preempt !== 1'b1) begin
            mismatched++;
            $display("FAIL preempt_fire: got %b id=%0d preempt=%b expected 0001 id=0 preempt=1",
                     grant, grant_id, preempt);
        end
        step();
        compared++;
        if (grant !== 4'b0010 || preempt !== 1'b0) begin
            mismatched++;
            $display("FAIL preempt_pulse_end: got %b preempt=%b expected 0010 preempt=0",
                     grant, preempt);
        end
`else
        for (int i = 0; i < 105; i++) begin
            step();
            compared++;
            if (grant !== 4'b0010 || preempt !== 1'b0) begin
                mismatched++;
                $display("FAIL lock_indefinite cycle %0d: got %b preempt=%b expected 0010 preempt=0",
                         i, grant, preempt);
            end
        end
`endif
    endtask

    task automatic test_async_reset();
        req  = 4'b1000;
        lock = 4'b1000;
        step();
        step();
        compared++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            mismatched++;
            $display("FAIL async_setup: got %b id=%0d expected 1000 id=3", grant, grant_id);
        end
        #2;
        reset_n = 1'b0;
        #1;
        compared++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0 || preempt !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset_drop: got %b valid=%b id=%0d preempt=%b expected 0000/0/0/0",
                     grant, grant_valid, grant_id, preempt);
        end
        req  = 4'b0110;
        lock = 4'b0000;
        #1;
        reset_n = 1'b1;
        step();
        compared++;
        if (grant !== 4'b0010 || grant_id !== 2'd1) begin
            mismatched++;
            $display("FAIL async_restart: got %b id=%0d expected 0010 id=1", grant, grant_id);
        end
        step();
        compared++;
        if (grant !== 4'b0100 || grant_id !== 2'd2) begin
            mismatched++;
            $display("FAIL async_restart_next: got %b id=%0d expected 0100 id=2", grant, grant_id);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req     = '0;
        en      = '0;
        lock    = '0;
        test_reset();
        test_rotation();
        test_mask_wrap();
        test_lock();
        test_preempt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
